// File: rtl/ide_arbiter.sv
// Round-robin arbiter sharing one ide_disk single-block engine between two requesters.
// Adds a per-port LBA partition base, steers buffer strobes to the owner and aborts hung transfers.
module ide_arbiter #(
    parameter logic [23:0] LBA_BASE0 = 24'h000000,
    parameter logic [23:0] LBA_BASE1 = 24'h010000,
    parameter int unsigned TIMEOUT   = 2**20,
    parameter int unsigned TMR_W     = 21
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        r0_read_req_i,
    input  logic        r0_write_req_i,
    input  logic [23:0] r0_lba_i,
    output logic        r0_done_o,
    output logic        r0_error_o,
    output logic [7:0]  r0_buf_addr_o,
    output logic        r0_buf_rd_o,
    output logic        r0_buf_wr_o,
    output logic [11:0] r0_buf_out_o,
    input  logic [11:0] r0_buf_in_i,
    input  logic        r1_read_req_i,
    input  logic        r1_write_req_i,
    input  logic [23:0] r1_lba_i,
    output logic        r1_done_o,
    output logic        r1_error_o,
    output logic [7:0]  r1_buf_addr_o,
    output logic        r1_buf_rd_o,
    output logic        r1_buf_wr_o,
    output logic [11:0] r1_buf_out_o,
    input  logic [11:0] r1_buf_in_i,
    output logic [23:0] ide_lba_o,
    output logic        ide_read_req_o,
    output logic        ide_write_req_o,
    output logic        ide_reset_o,
    input  logic        ide_done_i,
    input  logic        ide_error_i,
    input  logic [7:0]  buffer_addr_i,
    input  logic        buffer_rd_i,
    input  logic        buffer_wr_i,
    input  logic [11:0] buffer_out_i,
    output logic [11:0] buffer_in_o,
    output logic        busy_o,
    output logic        owner_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [23:0]      lba_q, lba_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             ide_rst_q, ide_rst_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             err_q, err_d;
    logic             hold_q, hold_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic pend0, pend1, grantPort, opWrite;
    logic inBusy, sel0, sel1;

    assign pend0 = r0_read_req_i | r0_write_req_i;
    assign pend1 = r1_read_req_i | r1_write_req_i;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        lba_d     = lba_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        ide_rst_d = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = 1'b0;
        hold_d    = 1'b0;
        tmr_d     = tmr_q;
        grantPort = (pend0 & pend1) ? ~last_q : pend1;
        opWrite   = grantPort ? r1_write_req_i : r0_write_req_i;
        case (state_q)
            S_IDLE: begin
                if (pend0 | pend1) begin
                    owner_d = grantPort;
                    last_d  = grantPort;
                    wr_d    = opWrite;
                    rd_d    = ~opWrite;
                    lba_d   = grantPort ? (r1_lba_i + LBA_BASE1) : (r0_lba_i + LBA_BASE0);
                    tmr_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // A completion on the same cycle as the watchdog expiry still counts as success.
                if (ide_done_i) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    err_d   = ide_error_i;
                    state_d = S_GAP;
                end else if (tmr_q == TMR_LAST) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    ide_rst_d = 1'b1;
                    done0_d   = ~owner_q;
                    done1_d   = owner_q;
                    err_d     = 1'b1;
                    state_d   = S_ABORT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_ABORT: begin
                if (!hold_q) begin
                    ide_rst_d = 1'b1;
                    hold_d    = 1'b1;
                end else begin
                    state_d = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            lba_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ide_rst_q <= 1'b1;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            lba_q     <= lba_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            ide_rst_q <= ide_rst_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            tmr_q     <= tmr_d;
        end
    end

    // Buffer traffic reaches only the owner, and only while the engine is actually busy.
    assign inBusy = (state_q == S_BUSY);
    assign sel0   = inBusy & ~owner_q;
    assign sel1   = inBusy & owner_q;

    assign r0_buf_addr_o = sel0 ? buffer_addr_i : 8'd0;
    assign r0_buf_rd_o   = sel0 & buffer_rd_i;
    assign r0_buf_wr_o   = sel0 & buffer_wr_i;
    assign r0_buf_out_o  = sel0 ? buffer_out_i : 12'd0;
    assign r1_buf_addr_o = sel1 ? buffer_addr_i : 8'd0;
    assign r1_buf_rd_o   = sel1 & buffer_rd_i;
    assign r1_buf_wr_o   = sel1 & buffer_wr_i;
    assign r1_buf_out_o  = sel1 ? buffer_out_i : 12'd0;
    assign buffer_in_o   = sel0 ? r0_buf_in_i : (sel1 ? r1_buf_in_i : 12'd0);

    assign r0_done_o       = done0_q;
    assign r1_done_o       = done1_q;
    assign r0_error_o      = done0_q & err_q;
    assign r1_error_o      = done1_q & err_q;
    assign ide_lba_o       = lba_q;
    assign ide_read_req_o  = rd_q;
    assign ide_write_req_o = wr_q;
    assign ide_reset_o     = ide_rst_q;
    assign busy_o          = (state_q != S_IDLE);
    assign owner_o         = owner_q;

endmodule

// File: tb/tb_ide_arbiter.sv
// Directed bench for ide_arbiter: expected completions go into a scoreboard queue and
// a negedge monitor pops and compares them whenever a done pulse appears.
module tb_ide_arbiter;

    localparam int TO = 300;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [23:0] lba;
    } expT;

    logic        clk;
    logic        resetN;
    logic        r0ReadReq, r0WriteReq, r1ReadReq, r1WriteReq;
    logic [23:0] r0Lba, r1Lba;
    logic        r0Done, r0Error, r1Done, r1Error;
    logic [7:0]  r0BufAddr, r1BufAddr;
    logic        r0BufRd, r0BufWr, r1BufRd, r1BufWr;
    logic [11:0] r0BufOut, r1BufOut, r0BufIn, r1BufIn;
    logic [23:0] ideLba;
    logic        ideReadReq, ideWriteReq, ideReset;
    logic        ideDone, ideError;
    logic [7:0]  bufferAddr;
    logic        bufferRd, bufferWr;
    logic [11:0] bufferOut, bufferIn;
    logic        busy, owner;

    int   checks = 0;
    int   errors = 0;
    expT  expQ[$];
    expT  monExp;

    ide_arbiter #(
        .LBA_BASE0(24'h000000),
        .LBA_BASE1(24'h010000),
        .TIMEOUT  (TO),
        .TMR_W    (9)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (resetN),
        .r0_read_req_i  (r0ReadReq),
        .r0_write_req_i (r0WriteReq),
        .r0_lba_i       (r0Lba),
        .r0_done_o      (r0Done),
        .r0_error_o     (r0Error),
        .r0_buf_addr_o  (r0BufAddr),
        .r0_buf_rd_o    (r0BufRd),
        .r0_buf_wr_o    (r0BufWr),
        .r0_buf_out_o   (r0BufOut),
        .r0_buf_in_i    (r0BufIn),
        .r1_read_req_i  (r1ReadReq),
        .r1_write_req_i (r1WriteReq),
        .r1_lba_i       (r1Lba),
        .r1_done_o      (r1Done),
        .r1_error_o     (r1Error),
        .r1_buf_addr_o  (r1BufAddr),
        .r1_buf_rd_o    (r1BufRd),
        .r1_buf_wr_o    (r1BufWr),
        .r1_buf_out_o   (r1BufOut),
        .r1_buf_in_i    (r1BufIn),
        .ide_lba_o      (ideLba),
        .ide_read_req_o (ideReadReq),
        .ide_write_req_o(ideWriteReq),
        .ide_reset_o    (ideReset),
        .ide_done_i     (ideDone),
        .ide_error_i    (ideError),
        .buffer_addr_i  (bufferAddr),
        .buffer_rd_i    (bufferRd),
        .buffer_wr_i    (bufferWr),
        .buffer_out_i   (bufferOut),
        .buffer_in_o    (bufferIn),
        .busy_o         (busy),
        .owner_o        (owner)
    );

    // Free-running clock; inputs change and outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point so every check is counted the same way.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic expT mkExp(input logic port, input logic err, input logic [23:0] lba);
        expT e;
        e.port = port;
        e.err  = err;
        e.lba  = lba;
        return e;
    endfunction

    // Drives one requester's level request and block number.
    task automatic applyStimulus(input logic port, input logic rd, input logic wr, input logic [23:0] lba);
        if (port) begin
            r1ReadReq = rd; r1WriteReq = wr; r1Lba = lba;
        end else begin
            r0ReadReq = rd; r0WriteReq = wr; r0Lba = lba;
        end
    endtask

    // Pulses ide_done, checks the done/GAP cycle, optionally drops requests in GAP,
    // and checks the following IDLE cycle.
    task automatic doneAndGap(input logic port, input logic err, input logic [1:0] dropMask);
        ideDone  = 1'b1;
        ideError = err;
        tick();
        ideDone  = 1'b0;
        ideError = 1'b0;
        checkOutput("gap_done_pulse", port ? r1Done : r0Done, 1);
        checkOutput("gap_busy", busy, 1);
        checkOutput("gap_req_cleared", {ideReadReq, ideWriteReq}, 0);
        if (dropMask[0]) applyStimulus(0, 0, 0, r0Lba);
        if (dropMask[1]) applyStimulus(1, 0, 0, r1Lba);
        tick();
        checkOutput("idle_after_gap", busy, 0);
        checkOutput("done_one_cycle", {r0Done, r1Done}, 0);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetN && (r0Done || r1Done)) begin
            checkOutput("done_expected", expQ.size() > 0, 1);
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                checkOutput("done_port", r1Done, monExp.port);
                checkOutput("done_exclusive", r0Done & r1Done, 0);
                checkOutput("done_error", r1Done ? r1Error : r0Error, monExp.err);
                checkOutput("done_lba", ideLba, monExp.lba);
            end
        end
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    // Directed test sequence.
    initial begin
        int okCnt;
        int leak;
        int earlyBad;
        logic order [3];
        logic [23:0] orderLba [3];

        resetN = 1'b0;
        r0ReadReq = 0; r0WriteReq = 0; r0Lba = '0; r0BufIn = '0;
        r1ReadReq = 0; r1WriteReq = 0; r1Lba = '0; r1BufIn = '0;
        ideDone = 0; ideError = 0;
        bufferAddr = '0; bufferRd = 0; bufferWr = 0; bufferOut = '0;

        tick(2);
        #1;
        checkOutput("rst_ide_reset", ideReset, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_reqs", {ideReadReq, ideWriteReq}, 0);
        checkOutput("rst_lba", ideLba, 0);
        checkOutput("rst_done", {r0Done, r1Done, r0Error, r1Error}, 0);
        resetN = 1'b1;
        tick();
        checkOutput("rst_release_ide_reset", ideReset, 0);

        // Port 0 read with 256 buffer writes routed to port 0 only.
        expQ.push_back(mkExp(0, 0, 24'h000005));
        applyStimulus(0, 1, 0, 24'h5);
        #1 checkOutput("t1_req_latency", ideReadReq, 0);
        tick();
        checkOutput("t1_read_req", ideReadReq, 1);
        checkOutput("t1_write_req", ideWriteReq, 0);
        checkOutput("t1_lba", ideLba, 24'h000005);
        checkOutput("t1_owner", owner, 0);
        okCnt = 0;
        leak  = 0;
        for (int i = 0; i < 256; i++) begin
            bufferWr   = 1'b1;
            bufferAddr = 8'(i);
            bufferOut  = 12'(i * 7);
            #1;
            if (r0BufWr && r0BufAddr == 8'(i) && r0BufOut == 12'(i * 7)) okCnt++;
            if (r1BufWr || r1BufOut != 0 || r1BufAddr != 0) leak++;
            tick();
        end
        bufferWr = 0; bufferAddr = '0; bufferOut = '0;
        checkOutput("t1_r0_wr_routed", okCnt, 256);
        checkOutput("t1_r1_leak", leak, 0);
        doneAndGap(0, 0, 2'b01);

        // Fresh reset so the contention order starts from port 0.
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();

        // Both ports write, held: r0, r1, r0 with a GAP and IDLE between grants.
        order[0] = 0; order[1] = 1; order[2] = 0;
        orderLba[0] = 24'h000100; orderLba[1] = 24'h010200; orderLba[2] = 24'h000100;
        for (int t = 0; t < 3; t++) expQ.push_back(mkExp(order[t], 0, orderLba[t]));
        applyStimulus(0, 0, 1, 24'h100);
        applyStimulus(1, 0, 1, 24'h200);
        for (int t = 0; t < 3; t++) begin
            tick();
            checkOutput("t2_owner", owner, order[t]);
            checkOutput("t2_write_req", {ideWriteReq, ideReadReq}, 2'b10);
            checkOutput("t2_lba", ideLba, orderLba[t]);
            doneAndGap(order[t], 0, (t == 2) ? 2'b11 : 2'b00);
        end
        tick();
        checkOutput("t2_no_regrant", busy, 0);

        // Port 1 read with partition base wrap and an engine error.
        expQ.push_back(mkExp(1, 1, 24'h00FFFF));
        applyStimulus(1, 1, 0, 24'hFFFFFF);
        tick();
        checkOutput("t3_lba_wrap", ideLba, 24'h00FFFF);
        checkOutput("t3_owner", owner, 1);
        checkOutput("t3_read_req", ideReadReq, 1);
        bufferWr = 1; bufferAddr = 8'h07; bufferOut = 12'hABC;
        #1;
        checkOutput("t3_r1_wr", {r1BufWr, r1BufAddr, r1BufOut}, {1'b1, 8'h07, 12'hABC});
        checkOutput("t3_r0_quiet", {r0BufWr, r0BufAddr, r0BufOut}, 0);
        bufferWr = 0; bufferAddr = '0; bufferOut = '0;
        doneAndGap(1, 1, 2'b10);

        // Port 0 read and write together: write wins, disk write path routed.
        expQ.push_back(mkExp(0, 0, 24'h000123));
        applyStimulus(0, 1, 1, 24'h123);
        tick();
        checkOutput("t4_write_wins", {ideWriteReq, ideReadReq}, 2'b10);
        bufferRd = 1; bufferAddr = 8'h42; r0BufIn = 12'h5A5; r1BufIn = 12'h111;
        #1;
        checkOutput("t4_r0_rd", {r0BufRd, r0BufAddr}, {1'b1, 8'h42});
        checkOutput("t4_buffer_in", bufferIn, 12'h5A5);
        checkOutput("t4_r1_rd_quiet", r1BufRd, 0);
        bufferRd = 0; bufferAddr = '0;
        doneAndGap(0, 0, 2'b01);
        #1 checkOutput("t4_buffer_in_idle", bufferIn, 0);

        // Stray ide_done while idle must be ignored.
        ideDone = 1; ideError = 1;
        tick();
        ideDone = 0; ideError = 0;
        tick();
        checkOutput("stray_done_busy", busy, 0);
        checkOutput("stray_done_pulse", {r0Done, r1Done}, 0);

        // Watchdog abort after TO busy cycles, ide_reset held for two cycles.
        expQ.push_back(mkExp(0, 1, 24'h000009));
        applyStimulus(0, 1, 0, 24'h9);
        earlyBad = 0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (ideReset || r0Done || !busy || !ideReadReq) earlyBad++;
        end
        checkOutput("t5_no_early_abort", earlyBad, 0);
        tick();
        checkOutput("t5_abort_done", {r0Done, r0Error}, 2'b11);
        checkOutput("t5_reset_cycle1", ideReset, 1);
        checkOutput("t5_req_cleared", ideReadReq, 0);
        tick();
        checkOutput("t5_reset_cycle2", ideReset, 1);
        checkOutput("t5_done_single", r0Done, 0);
        tick();
        checkOutput("t5_reset_released", ideReset, 0);
        checkOutput("t5_gap_busy", busy, 1);
        applyStimulus(0, 0, 0, 24'h0);
        tick();
        checkOutput("t5_idle", busy, 0);

        // Reset mid-transfer, then port 0 wins the first contention.
        applyStimulus(1, 1, 0, 24'h10);
        tick();
        checkOutput("t6_busy", {busy, owner}, 2'b11);
        bufferWr = 1;
        #2 resetN = 1'b0;
        #1;
        checkOutput("t6_async_ide_reset", ideReset, 1);
        checkOutput("t6_async_busy", busy, 0);
        checkOutput("t6_async_reqs", {ideReadReq, ideWriteReq}, 0);
        checkOutput("t6_async_lba", ideLba, 0);
        checkOutput("t6_async_buf", r1BufWr, 0);
        bufferWr = 0;
        expQ.push_back(mkExp(0, 0, 24'h000020));
        expQ.push_back(mkExp(1, 0, 24'h010010));
        applyStimulus(0, 0, 1, 24'h20);
        tick();
        checkOutput("t6_held_reset", ideReset, 1);
        resetN = 1'b1;
        tick();
        checkOutput("t6_first_owner", owner, 0);
        checkOutput("t6_first_write", ideWriteReq, 1);
        checkOutput("t6_reset_dropped", ideReset, 0);
        doneAndGap(0, 0, 2'b01);
        tick();
        checkOutput("t6_second_owner", owner, 1);
        checkOutput("t6_second_lba", ideLba, 24'h010010);
        checkOutput("t6_second_read", ideReadReq, 1);
        doneAndGap(1, 0, 2'b10);

        tick(3);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
